// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding word read per PC, result presented to decode with valid/ready.
// A redirect or a reset while a read is outstanding marks that read's response for discard.
module instr_fetch_unit #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              redirect,
  output logic              pc_advance,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_fault
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t state, state_nxt;
  logic   drop, drop_nxt;
  logic   load_pc, load_rsp, load_fault;
  logic   aligned;

  function automatic logic is_word_aligned(input logic [ADDR_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

  assign aligned       = is_word_aligned(pc_in);
  assign imem_req_addr = {pc_in[ADDR_W-1:2], 2'b00};

  always_comb begin
    state_nxt      = state;
    drop_nxt       = drop;
    imem_req_valid = 1'b0;
    id_valid       = 1'b0;
    pc_advance     = 1'b0;
    load_pc        = 1'b0;
    load_rsp       = 1'b0;
    load_fault     = 1'b0;

    // A stray response for a dropped read may also land before we are back in WAIT.
    if (drop && imem_rsp_valid && state != S_WAIT) drop_nxt = 1'b0;

    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (!redirect) begin
          if (!aligned) begin
            load_fault = 1'b1;
            state_nxt  = S_HOLD;
          end else begin
            imem_req_valid = 1'b1;
            if (imem_req_ready) begin
              load_pc   = 1'b1;
              state_nxt = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (redirect || drop) begin
            drop_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            load_rsp  = 1'b1;
            state_nxt = S_HOLD;
          end
        end else if (redirect) begin
          drop_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_nxt = S_REQ;
        end else begin
          id_valid = 1'b1;
          if (id_ready) begin
            pc_advance = 1'b1;
            state_nxt  = S_REQ;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      drop     <= (state == S_WAIT);
      id_instr <= '0;
      id_pc    <= '0;
      id_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
      if (load_pc) id_pc <= pc_in;
      if (load_fault) begin
        id_instr <= NOP_INSTR;
        id_pc    <= pc_in;
        id_fault <= 1'b1;
      end
      if (load_rsp) begin
        id_instr <= imem_rsp_data;
        id_fault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: drives memory/decode by hand, checks with immediate asserts.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        redirect;
  logic        pc_advance;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_fault;

  int checks = 0;
  int errors = 0;
  int adv_cnt = 0;
  int adv_snap;
  logic [31:0] prog [3] = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81B3};

  instr_fetch_unit #(.ADDR_W(32), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .redirect(redirect), .pc_advance(pc_advance),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_fault(id_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && pc_advance) adv_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pc_in = '0; redirect = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; id_ready = 1'b0;

    // 1: reset
    tick(); tick();
    chk("rst_id_valid", 32'(id_valid), 0);
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_pc_adv", 32'(pc_advance), 0);
    chk("rst_id_instr", id_instr, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_fault", 32'(id_fault), 0);
    rst = 1'b0; #1;
    chk("idle_req_valid", 32'(imem_req_valid), 0);
    tick();
    chk("req_after_rst", 32'(imem_req_valid), 1);
    chk("req_addr_0", imem_req_addr, 0);

    // 2: straight line, 1-cycle memory, always-ready decode
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_in = 32'(4 * i); imem_req_ready = 1'b1; #1;
      chk("sl_req_valid", 32'(imem_req_valid), 1);
      chk("sl_req_addr", imem_req_addr, 32'(4 * i));
      tick();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = prog[i]; #1;
      chk("sl_wait_id_valid", 32'(id_valid), 0);
      chk("sl_wait_req_valid", 32'(imem_req_valid), 0);
      tick();
      imem_rsp_valid = 1'b0; #1;
      chk("sl_id_valid", 32'(id_valid), 1);
      chk("sl_id_instr", id_instr, prog[i]);
      chk("sl_id_pc", id_pc, 32'(4 * i));
      chk("sl_id_fault", 32'(id_fault), 0);
      chk("sl_pc_adv", 32'(pc_advance), 1);
      tick();
    end
    chk("sl_adv_count", 32'(adv_cnt), 3);

    // 3: decode backpressure
    pc_in = 32'hC; imem_req_ready = 1'b1; id_ready = 1'b0; #1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00C0_0213;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'hFFFF_FFFF; adv_snap = adv_cnt;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_id_valid", 32'(id_valid), 1);
      chk("bp_id_instr", id_instr, 32'h00C0_0213);
      chk("bp_id_pc", id_pc, 32'hC);
      chk("bp_pc_adv", 32'(pc_advance), 0);
      tick();
    end
    id_ready = 1'b1; #1;
    chk("bp_release_adv", 32'(pc_advance), 1);
    tick();
    chk("bp_one_pulse", 32'(adv_cnt - adv_snap), 1);
    chk("bp_after_id_valid", 32'(id_valid), 0);

    // 4: redirect while waiting for memory
    pc_in = 32'h10; imem_req_ready = 1'b1; #1;
    chk("rd_req_addr", imem_req_addr, 32'h10);
    tick();
    imem_req_ready = 1'b0; redirect = 1'b1;
    tick();
    redirect = 1'b0; pc_in = 32'h40; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0BAD; #1;
    chk("rd_drop_id_valid", 32'(id_valid), 0);
    tick();
    imem_rsp_valid = 1'b0; #1;
    chk("rd_no_beat", 32'(id_valid), 0);
    chk("rd_req_valid", 32'(imem_req_valid), 1);
    chk("rd_req_addr_40", imem_req_addr, 32'h40);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0400_0293;
    tick();
    imem_rsp_valid = 1'b0; #1;
    chk("rd_id_valid", 32'(id_valid), 1);
    chk("rd_id_pc", id_pc, 32'h40);
    chk("rd_id_instr", id_instr, 32'h0400_0293);
    tick();

    // 5: misaligned PC, then redirect while holding
    pc_in = 32'h22; id_ready = 1'b0; imem_req_ready = 1'b1; #1;
    chk("mis_no_req", 32'(imem_req_valid), 0);
    tick();
    chk("mis_id_valid", 32'(id_valid), 1);
    chk("mis_id_instr", id_instr, 32'h0000_0013);
    chk("mis_id_pc", id_pc, 32'h22);
    chk("mis_id_fault", 32'(id_fault), 1);
    redirect = 1'b1; id_ready = 1'b1; #1;
    chk("mis_redir_id_valid", 32'(id_valid), 0);
    chk("mis_redir_adv", 32'(pc_advance), 0);
    tick();
    redirect = 1'b0; pc_in = 32'h50; imem_req_ready = 1'b0;

    // 6: memory stall, slow response, reset during WAIT
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("st_req_valid", 32'(imem_req_valid), 1);
      chk("st_req_addr", imem_req_addr, 32'h50);
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_wait_id_valid", 32'(id_valid), 0);
      tick();
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00A0_0313;
    tick();
    imem_rsp_valid = 1'b0; #1;
    chk("st_id_valid", 32'(id_valid), 1);
    chk("st_id_instr", id_instr, 32'h00A0_0313);
    chk("st_id_pc", id_pc, 32'h50);
    chk("st_id_fault", 32'(id_fault), 0);
    tick();
    chk("st_single_beat", 32'(id_valid), 0);

    pc_in = 32'h54; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("wr_id_valid", 32'(id_valid), 0);
    chk("wr_req_valid", 32'(imem_req_valid), 0);
    chk("wr_id_instr", id_instr, 0);
    tick();
    chk("wr_req_again", 32'(imem_req_valid), 1);
    chk("wr_req_addr", imem_req_addr, 32'h54);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hFFFF_FFFF;
    tick();
    imem_rsp_valid = 1'b0; #1;
    chk("wr_stray_ignored", 32'(id_valid), 0);
    chk("wr_rerequest", 32'(imem_req_valid), 1);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00B0_0393;
    tick();
    imem_rsp_valid = 1'b0; #1;
    chk("wr_id_valid_beat", 32'(id_valid), 1);
    chk("wr_id_instr_beat", id_instr, 32'h00B0_0393);
    chk("wr_id_pc_beat", id_pc, 32'h54);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
